// File: rtl/pcie_tag_cpl_tracker_pkg.sv
// Shared PCIe completion-tracking definitions: tag type, default sizing and tag
// pointer arithmetic for tag spaces that need not be a power of two.
package pcie_tag_cpl_tracker_pkg;

    localparam int unsigned MAX_TLP_TAGS     = 256;
    localparam int unsigned CPL_CREDIT_DWORD = 10000;
    localparam int unsigned PCIE_CPL_TIMEOUT = 12500000;
    localparam int unsigned CPL_TIME_WIDTH   = 26;
    localparam int unsigned CPL_LEN_WIDTH    = 11;

    // Wide enough for the largest tag space; callers truncate to their own width.
    typedef logic [7:0] tlp_tag_t;

    function automatic tlp_tag_t incr_tlp_tag(input tlp_tag_t tag, input tlp_tag_t max);
        return (tag >= max) ? tlp_tag_t'(0) : tag + tlp_tag_t'(1);
    endfunction

endpackage

// File: rtl/pcie_cpl_timeout_scanner.sv
// Completion timeout scanner: free-running timestamp, round-robin tag visit
// pointer and elapsed-time compare against the visited tag's start time.
module pcie_cpl_timeout_scanner
    import pcie_tag_cpl_tracker_pkg::*;
#(
    parameter int unsigned NUM_TAGS    = MAX_TLP_TAGS,
    parameter int unsigned CPL_TIMEOUT = PCIE_CPL_TIMEOUT,
    parameter int unsigned TIME_WIDTH  = CPL_TIME_WIDTH,
    localparam int unsigned TAG_W      = $clog2(NUM_TAGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [TIME_WIDTH-1:0] start_time,
    output logic [TAG_W-1:0]      scan_ptr,
    output logic [TIME_WIDTH-1:0] now,
    output logic                  expired
);

    logic [TAG_W-1:0]      scan_ptr_q, scan_ptr_d;
    logic [TIME_WIDTH-1:0] now_q, now_d;
    logic [TIME_WIDTH-1:0] elapsed;

    always_comb begin
        scan_ptr_d = TAG_W'(incr_tlp_tag(tlp_tag_t'(scan_ptr_q), tlp_tag_t'(NUM_TAGS - 1)));
        now_d      = now_q + TIME_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_ptr_q <= '0;
            now_q      <= '0;
        end else begin
            scan_ptr_q <= scan_ptr_d;
            now_q      <= now_d;
        end
    end

    // Modular subtraction keeps the compare correct across timestamp wrap.
    always_comb begin
        elapsed = now_q - start_time;
        expired = (elapsed >= TIME_WIDTH'(CPL_TIMEOUT));
    end

    assign scan_ptr = scan_ptr_q;
    assign now      = now_q;

endmodule

// File: rtl/pcie_tag_cpl_tracker.sv
// Non-posted read tag allocator and completion tracker: in-order tag grant with
// completion credit reservation, split-completion accounting and timeout/unexpected detection.
module pcie_tag_cpl_tracker
    import pcie_tag_cpl_tracker_pkg::*;
#(
    parameter int unsigned NUM_TAGS      = MAX_TLP_TAGS,
    parameter int unsigned CPL_CREDIT_DW = CPL_CREDIT_DWORD,
    parameter int unsigned CPL_TIMEOUT   = PCIE_CPL_TIMEOUT,
    parameter int unsigned TIME_WIDTH    = CPL_TIME_WIDTH,
    parameter int unsigned LEN_WIDTH     = CPL_LEN_WIDTH,
    localparam int unsigned TAG_W        = $clog2(NUM_TAGS),
    localparam int unsigned CREDIT_W     = $clog2(CPL_CREDIT_DW + 1),
    localparam int unsigned OUT_W        = $clog2(NUM_TAGS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_req,
    input  logic [LEN_WIDTH-1:0] alloc_len,
    output logic                 alloc_gnt,
    output logic [TAG_W-1:0]     alloc_tag,
    input  logic                 cpl_valid,
    input  logic [TAG_W-1:0]     cpl_tag,
    input  logic [LEN_WIDTH-1:0] cpl_len,
    input  logic                 cpl_last,
    output logic [CREDIT_W-1:0]  credit_avail,
    output logic [OUT_W-1:0]     outstanding,
    output logic                 err_cpl_timeout,
    output logic [TAG_W-1:0]     timeout_tag,
    output logic                 err_unexp_cpl,
    output logic [TAG_W-1:0]     unexp_tag
);

    // Headroom for credit plus two same-cycle returns before the saturating clamp.
    localparam int unsigned SUM_W = ((CREDIT_W > LEN_WIDTH) ? CREDIT_W : LEN_WIDTH) + 2;
    localparam logic [TAG_W:0] TAG_LIMIT = (TAG_W + 1)'(NUM_TAGS);

    logic [NUM_TAGS-1:0]   busy_q, busy_d;
    logic [LEN_WIDTH-1:0]  rem_q [NUM_TAGS];
    logic [LEN_WIDTH-1:0]  rem_d [NUM_TAGS];
    logic [TIME_WIDTH-1:0] start_q [NUM_TAGS];

    logic [TAG_W-1:0]    alloc_ptr_q, alloc_ptr_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [OUT_W-1:0]    outstanding_q, outstanding_d;
    logic                err_to_q, err_to_d;
    logic                err_unexp_q, err_unexp_d;
    logic [TAG_W-1:0]    to_tag_q, to_tag_d;
    logic [TAG_W-1:0]    unexp_tag_q, unexp_tag_d;

    logic [SUM_W-1:0]      credit_sum;
    logic [LEN_WIDTH-1:0]  cpl_ret, to_ret;
    logic                  credit_ok;
    logic                  cpl_in_range, cpl_hit, cpl_over, cpl_free, to_hit;
    logic [TAG_W-1:0]      scan_ptr;
    logic [TIME_WIDTH-1:0] now;
    logic                  expired;

    pcie_cpl_timeout_scanner #(
        .NUM_TAGS    (NUM_TAGS),
        .CPL_TIMEOUT (CPL_TIMEOUT),
        .TIME_WIDTH  (TIME_WIDTH)
    ) u_scanner (
        .clk        (clk),
        .rst        (rst),
        .start_time (start_q[scan_ptr]),
        .scan_ptr   (scan_ptr),
        .now        (now),
        .expired    (expired)
    );

    assign credit_ok = (SUM_W'(credit_q) >= SUM_W'(alloc_len));
    assign alloc_gnt = !rst && alloc_req && !busy_q[alloc_ptr_q] && credit_ok;
    assign alloc_tag = alloc_ptr_q;

    // busy_q is the registered view, so a tag granted this cycle still reads free here.
    assign cpl_in_range = ({1'b0, cpl_tag} < TAG_LIMIT);
    assign cpl_hit      = cpl_valid && cpl_in_range && busy_q[cpl_tag];
    assign to_hit       = busy_q[scan_ptr] && expired && !(cpl_valid && (cpl_tag == scan_ptr));

    always_comb begin
        busy_d   = busy_q;
        rem_d    = rem_q;
        cpl_ret  = '0;
        to_ret   = '0;
        cpl_over = 1'b0;
        cpl_free = 1'b0;
        if (cpl_hit) begin
            cpl_over = (cpl_len > rem_q[cpl_tag]);
            cpl_free = cpl_over || cpl_last || (cpl_len == rem_q[cpl_tag]);
            if (cpl_free) begin
                // Whatever was still reserved goes back, including leftover on early last.
                cpl_ret          = rem_q[cpl_tag];
                busy_d[cpl_tag]  = 1'b0;
                rem_d[cpl_tag]   = '0;
            end else begin
                cpl_ret          = cpl_len;
                rem_d[cpl_tag]   = rem_q[cpl_tag] - cpl_len;
            end
        end
        if (to_hit) begin
            to_ret           = rem_q[scan_ptr];
            busy_d[scan_ptr] = 1'b0;
            rem_d[scan_ptr]  = '0;
        end
        if (alloc_gnt) begin
            busy_d[alloc_ptr_q] = 1'b1;
            rem_d[alloc_ptr_q]  = alloc_len;
        end
    end

    always_comb begin
        alloc_ptr_d = alloc_ptr_q;
        if (alloc_gnt) begin
            alloc_ptr_d = TAG_W'(incr_tlp_tag(tlp_tag_t'(alloc_ptr_q),
                                              tlp_tag_t'(NUM_TAGS - 1)));
        end

        credit_sum = SUM_W'(credit_q) - (alloc_gnt ? SUM_W'(alloc_len) : SUM_W'(0))
                   + SUM_W'(cpl_ret) + SUM_W'(to_ret);
        credit_d   = (credit_sum > SUM_W'(CPL_CREDIT_DW)) ? CREDIT_W'(CPL_CREDIT_DW)
                                                           : credit_sum[CREDIT_W-1:0];

        outstanding_d = outstanding_q + OUT_W'(alloc_gnt) - OUT_W'(cpl_free) - OUT_W'(to_hit);

        err_unexp_d = cpl_valid && (!cpl_hit || cpl_over);
        unexp_tag_d = err_unexp_d ? cpl_tag : unexp_tag_q;
        err_to_d    = to_hit;
        to_tag_d    = to_hit ? scan_ptr : to_tag_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q        <= '0;
            alloc_ptr_q   <= '0;
            credit_q      <= CREDIT_W'(CPL_CREDIT_DW);
            outstanding_q <= '0;
            err_to_q      <= 1'b0;
            err_unexp_q   <= 1'b0;
            to_tag_q      <= '0;
            unexp_tag_q   <= '0;
        end else begin
            busy_q        <= busy_d;
            alloc_ptr_q   <= alloc_ptr_d;
            credit_q      <= credit_d;
            outstanding_q <= outstanding_d;
            err_to_q      <= err_to_d;
            err_unexp_q   <= err_unexp_d;
            to_tag_q      <= to_tag_d;
            unexp_tag_q   <= unexp_tag_d;
        end
    end

    // Length and timestamp are only meaningful while the tag is busy.
    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        if (alloc_gnt) begin
            start_q[alloc_ptr_q] <= now;
        end
    end

    assign credit_avail    = credit_q;
    assign outstanding     = outstanding_q;
    assign err_cpl_timeout = err_to_q;
    assign timeout_tag     = to_tag_q;
    assign err_unexp_cpl   = err_unexp_q;
    assign unexp_tag       = unexp_tag_q;

    a_alloc_len_nonzero : assert property (@(posedge clk) disable iff (rst)
        alloc_req |-> (alloc_len != '0));

    a_credit_bounded : assert property (@(posedge clk) disable iff (rst)
        credit_sum <= SUM_W'(CPL_CREDIT_DW));

endmodule

// File: tb/tb_pcie_tag_cpl_tracker.sv
// Bench for pcie_tag_cpl_tracker: directed scenarios plus random traffic, all
// checked against a per-tag behavioural model of allocation, credit and timeouts.
module tb_pcie_tag_cpl_tracker;

    localparam int NT = 6;
    localparam int CR = 64;
    localparam int TO = 100;
    localparam int TW = 26;
    localparam int LW = 11;
    localparam int TAG_W = $clog2(NT);
    localparam int CW = $clog2(CR + 1);
    localparam int OW = $clog2(NT + 1);

    logic clk = 1'b0;
    logic rst;
    logic alloc_req;
    logic [LW-1:0] alloc_len;
    logic alloc_gnt;
    logic [TAG_W-1:0] alloc_tag;
    logic cpl_valid;
    logic [TAG_W-1:0] cpl_tag;
    logic [LW-1:0] cpl_len;
    logic cpl_last;
    logic [CW-1:0] credit_avail;
    logic [OW-1:0] outstanding;
    logic err_cpl_timeout;
    logic [TAG_W-1:0] timeout_tag;
    logic err_unexp_cpl;
    logic [TAG_W-1:0] unexp_tag;

    always #5 clk = ~clk;

    pcie_tag_cpl_tracker #(
        .NUM_TAGS      (NT),
        .CPL_CREDIT_DW (CR),
        .CPL_TIMEOUT   (TO),
        .TIME_WIDTH    (TW),
        .LEN_WIDTH     (LW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .alloc_req       (alloc_req),
        .alloc_len       (alloc_len),
        .alloc_gnt       (alloc_gnt),
        .alloc_tag       (alloc_tag),
        .cpl_valid       (cpl_valid),
        .cpl_tag         (cpl_tag),
        .cpl_len         (cpl_len),
        .cpl_last        (cpl_last),
        .credit_avail    (credit_avail),
        .outstanding     (outstanding),
        .err_cpl_timeout (err_cpl_timeout),
        .timeout_tag     (timeout_tag),
        .err_unexp_cpl   (err_unexp_cpl),
        .unexp_tag       (unexp_tag)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, obs, exp);
        end
    endtask

    // Behavioural model: per-tag busy/remaining/start, plus total credit and time.
    bit m_valid = 0;
    bit m_busy [NT];
    int m_rem [NT];
    int m_start [NT];
    int m_credit, m_ptr, m_now;
    bit m_to, m_unexp;
    int m_to_tag, m_unexp_tag;

    int cyc = 0;
    bit obs_gnt, obs_to;
    int obs_tag, obs_to_tag;

    function automatic int busy_count();
        int n = 0;
        for (int i = 0; i < NT; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NT; i++) begin
            m_busy[i] = 0;
            m_rem[i]  = 0;
        end
        m_credit = CR;
        m_ptr    = 0;
        m_now    = 0;
        m_to     = 0;
        m_unexp  = 0;
        m_valid  = 1;
    endtask

    task automatic model_step(input bit g);
        int s, t;
        bit s_exp;
        s     = m_now % NT;
        s_exp = m_busy[s] && (m_now - m_start[s] >= TO);
        m_to    = 0;
        m_unexp = 0;
        if (cpl_valid) begin
            t = int'(cpl_tag);
            if (!m_busy[t]) begin
                m_unexp = 1; m_unexp_tag = t;
            end else if (int'(cpl_len) > m_rem[t]) begin
                m_unexp = 1; m_unexp_tag = t;
                m_credit += m_rem[t];
                m_busy[t] = 0;
            end else begin
                m_credit += int'(cpl_len);
                m_rem[t] -= int'(cpl_len);
                if (cpl_last || m_rem[t] == 0) begin
                    m_credit += m_rem[t];
                    m_busy[t] = 0;
                end
            end
        end
        if (s_exp && !(cpl_valid && int'(cpl_tag) == s)) begin
            m_to = 1; m_to_tag = s;
            m_credit += m_rem[s];
            m_busy[s] = 0;
        end
        if (g) begin
            m_busy[m_ptr]  = 1;
            m_rem[m_ptr]   = int'(alloc_len);
            m_start[m_ptr] = m_now;
            m_credit      -= int'(alloc_len);
            m_ptr          = (m_ptr + 1) % NT;
        end
        m_now++;
    endtask

    // Called at a negedge with inputs set; checks, advances one clock, returns at next negedge.
    task automatic cycle();
        bit g;
        #1;
        g = !rst && alloc_req && !m_busy[m_ptr] && (m_credit >= int'(alloc_len));
        obs_gnt    = alloc_gnt;
        obs_tag    = int'(alloc_tag);
        obs_to     = err_cpl_timeout;
        obs_to_tag = int'(timeout_tag);
        if (m_valid) begin
            check_eq("alloc_gnt", alloc_gnt, g);
            if (g) check_eq("alloc_tag", alloc_tag, m_ptr);
            check_eq("credit_avail", credit_avail, m_credit);
            check_eq("outstanding", outstanding, busy_count());
            check_eq("err_cpl_timeout", err_cpl_timeout, m_to);
            if (m_to) check_eq("timeout_tag", timeout_tag, m_to_tag);
            check_eq("err_unexp_cpl", err_unexp_cpl, m_unexp);
            if (m_unexp) check_eq("unexp_tag", unexp_tag, m_unexp_tag);
        end
        @(posedge clk);
        if (rst) model_reset();
        else if (m_valid) model_step(g);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle();
        alloc_req = 0; alloc_len = 1;
        cpl_valid = 0; cpl_tag = 0; cpl_len = 1; cpl_last = 0;
    endtask

    task automatic do_alloc(input int len);
        alloc_req = 1; alloc_len = LW'(len);
        cycle();
        alloc_req = 0;
    endtask

    task automatic do_cpl(input int tag, input int len, input bit last);
        cpl_valid = 1; cpl_tag = TAG_W'(tag); cpl_len = LW'(len); cpl_last = last;
        cycle();
        cpl_valid = 0; cpl_last = 0;
    endtask

    task automatic rst_dut();
        idle();
        rst = 1;
        cycle();
        cycle();
        rst = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int t_gnt, p_seen;
        bit found;
        rst = 1;
        idle();
        @(negedge clk);
        rst_dut();
        check_eq("reset_credit", credit_avail, CR);
        check_eq("reset_outstanding", outstanding, 0);

        // Fill the tag space, then the pointer sits on busy tag 0.
        for (int i = 0; i < NT; i++) begin
            do_alloc(8);
            check_eq("fill_gnt", obs_gnt, 1);
            check_eq("fill_tag", obs_tag, i);
        end
        check_eq("fill_credit", credit_avail, 16);
        check_eq("fill_outstanding", outstanding, 6);
        do_alloc(8);
        check_eq("full_no_gnt", obs_gnt, 0);

        // Free everything and allocate round the wrap.
        for (int i = 0; i < NT; i++) do_cpl(i, 8, 1);
        check_eq("freed_credit", credit_avail, CR);
        check_eq("freed_outstanding", outstanding, 0);
        for (int i = 0; i < NT; i++) begin
            do_alloc(8);
            check_eq("wrap_tag", obs_tag, i);
        end
        do_cpl(0, 8, 1);
        do_alloc(8);
        check_eq("wrap_gnt", obs_gnt, 1);
        check_eq("wrap_tag0", obs_tag, 0);

        // Split and early-last completions, then an unexpected one.
        rst_dut();
        for (int i = 0; i < 3; i++) do_alloc(8);
        do_cpl(2, 4, 0);
        check_eq("split1_credit", credit_avail, 44);
        check_eq("split1_outstanding", outstanding, 3);
        do_cpl(2, 4, 1);
        check_eq("split2_credit", credit_avail, 48);
        check_eq("split2_outstanding", outstanding, 2);
        do_cpl(1, 2, 1);
        check_eq("early_last_credit", credit_avail, 56);
        check_eq("early_last_outstanding", outstanding, 1);
        do_cpl(3, 4, 1);
        check_eq("unexp_pulse", err_unexp_cpl, 1);
        check_eq("unexp_tag_val", unexp_tag, 3);
        check_eq("unexp_credit", credit_avail, 56);

        // Timeout on tag 0 with no completion.
        rst_dut();
        t_gnt = cyc;
        do_alloc(8);
        found  = 0;
        p_seen = 0;
        for (int i = 0; i < 150 && !found; i++) begin
            cycle();
            if (obs_to) begin
                found  = 1;
                p_seen = cyc - 1;
            end
        end
        check_eq("timeout_seen", found, 1);
        if (found) begin
            check_eq("timeout_window", (p_seen >= t_gnt + TO) && (p_seen <= t_gnt + TO + 7), 1);
            check_eq("timeout_tag0", obs_to_tag, 0);
        end
        check_eq("timeout_credit", credit_avail, CR);
        for (int i = 1; i < NT; i++) do_alloc(8);
        do_alloc(8);
        check_eq("regrant_gnt", obs_gnt, 1);
        check_eq("regrant_tag", obs_tag, 0);

        // Credit limit: a request waits until a completion returns enough credit.
        rst_dut();
        do_alloc(60);
        check_eq("limit_credit", credit_avail, 4);
        alloc_req = 1; alloc_len = 8;
        cycle();
        check_eq("limit_no_gnt", obs_gnt, 0);
        cpl_valid = 1; cpl_tag = 0; cpl_len = 8; cpl_last = 0;
        cycle();
        check_eq("limit_still_no_gnt", obs_gnt, 0);
        cpl_valid = 0;
        cycle();
        check_eq("limit_gnt", obs_gnt, 1);
        check_eq("limit_tag", obs_tag, 1);
        alloc_req = 0;

        // Reset in the middle of traffic.
        rst_dut();
        for (int i = 0; i < 3; i++) do_alloc(8);
        rst = 1;
        cycle();
        rst = 0;
        check_eq("midrst_credit", credit_avail, CR);
        check_eq("midrst_outstanding", outstanding, 0);
        check_eq("midrst_no_to", err_cpl_timeout, 0);
        check_eq("midrst_no_unexp", err_unexp_cpl, 0);

        // Random traffic against the model; sparse completions so timeouts occur.
        for (int n = 0; n < 3000; n++) begin
            int t;
            rst       = ($urandom_range(0, 499) == 0);
            alloc_req = ($urandom_range(0, 2) == 0);
            alloc_len = LW'($urandom_range(1, 16));
            cpl_valid = ($urandom_range(0, 7) == 0);
            t         = $urandom_range(0, NT - 1);
            cpl_tag   = TAG_W'(t);
            cpl_len   = m_busy[t] ? LW'($urandom_range(1, m_rem[t] + 2))
                                  : LW'($urandom_range(1, 8));
            cpl_last  = ($urandom_range(0, 3) == 0);
            cycle();
        end
        rst = 0;
        idle();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
